// File: rtl/dual_pkg.sv
// dual_pkg: dual-rail types, default widths and port FSM states
package dual_pkg;
  typedef struct packed {logic t; logic f;} Dual;
  localparam int size = 4;
  localparam logic true = 1'b1;
  localparam logic false = 1'b0;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;
endpackage

// File: rtl/dual_sync.sv
// dual_sync: two-flop synchronizer over every rail of a dual-rail array
module dual_sync import dual_pkg::*; #(
  parameter int W = size
) (
  input  logic        clk,
  input  Dual [W-1:0] d,
  output Dual [W-1:0] q
);
  Dual [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk) begin
    meta_q <= d;
    sync_q <= meta_q;
  end
  assign q = sync_q;
endmodule

// File: rtl/bus_sync_port.sv
// bus_sync_port: valid/ready requester driving one two-phase dual-rail bus slot
module bus_sync_port import dual_pkg::*; #(
  parameter int INPUT = size,
  parameter int OUTPUT = size,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [INPUT-1:0]  req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [OUTPUT-1:0] resp_data,
  output Dual [INPUT-1:0]   user_input,
  input  Dual [OUTPUT-1:0]  user_output,
  output logic              timeout,
  output logic              proto_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  Dual [INPUT-1:0] in_q, in_d, in_tog;
  Dual [OUTPUT-1:0] prev_q, prev_d, out_s;
  logic [OUTPUT-1:0] data_q, data_d, dt, df;
  logic timeout_q, timeout_d, perr_q, perr_d, bad, full;

  dual_sync #(.W(OUTPUT)) u_sync (.clk(clk), .d(user_output), .q(out_s));

  for (genvar i = 0; i < OUTPUT; i++) begin : g_diff
    assign dt[i] = out_s[i].t ^ prev_q[i].t;
    assign df[i] = out_s[i].f ^ prev_q[i].f;
  end

  // a 1 toggles the t rail, a 0 toggles the f rail
  for (genvar i = 0; i < INPUT; i++) begin : g_enc
    assign in_tog[i] = in_q[i] ^ {req_data[i], ~req_data[i]};
  end

  assign bad = |(dt & df);
  assign full = &(dt | df) && !bad;
  assign cnt_inc = cnt_q == TMAX ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q == IDLE ? (req_valid ? WAIT : IDLE)
            : state_q == WAIT ? (bad ? IDLE : full ? HOLD : WAIT)
            : (resp_ready ? IDLE : HOLD);
    in_d = (state_q == IDLE && req_valid) ? in_tog : in_q;
    prev_d = (bad || full) ? out_s : prev_q;
    data_d = (state_q == WAIT && full) ? dt : data_q;
    cnt_d = (state_q == WAIT && state_d == WAIT) ? cnt_inc : '0;
    timeout_d = timeout_q || (state_q == WAIT && cnt_inc == TMAX);
    // any token outside WAIT is unexpected and is absorbed as an error
    perr_d = perr_q || bad || (full && state_q != WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      prev_q <= out_s;
      data_q <= '0;
      timeout_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      prev_q <= prev_d;
      data_q <= data_d;
      timeout_q <= timeout_d;
      perr_q <= perr_d;
      in_q <= in_d;
    end
  end

  assign req_ready = !reset && state_q == IDLE;
  assign resp_valid = !reset && state_q == HOLD;
  assign resp_data = reset ? '0 : data_q;
  assign timeout = !reset && timeout_q;
  assign proto_err = !reset && perr_q;
  assign user_input = in_q;
endmodule

// File: tb/tb_bus_sync_port.sv
// tb_bus_sync_port: random and directed checks against a cycle-level behavioural model with an echoing bus
module tb_bus_sync_port;
  import dual_pkg::*;
  localparam int TO = 1024;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, resp_ready = 1'b0;
  logic [3:0] req_data = '0;
  logic req_ready, resp_valid, timeout, proto_err;
  logic [3:0] resp_data;
  Dual [3:0] user_input, user_output;
  logic [7:0] uo = '0;
  assign user_output = uo;

  bus_sync_port #(.INPUT(4), .OUTPUT(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .user_input(user_input), .user_output(user_output),
    .timeout(timeout), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // model: ph 0 = free, 1 = awaiting echo, 2 = response held
  int ph = 0, cyc = 0, mode = 0, m_cnt = 0, checks = 0, errors = 0;
  int at[8] = '{default: -1};
  logic [7:0] m_ui = '0, m_s1 = '0, m_s2 = '0, m_prev = '0;
  logic [3:0] m_data = '0;
  bit m_tmo = 1'b0, m_perr = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic [7:0] d;
    int nany, nboth, dl;
    bit bad, full;
    cyc++;
    d = m_s2 ^ m_prev;
    nany = 0;
    nboth = 0;
    for (int i = 0; i < 4; i++) begin
      nany += int'(d[2*i+1] | d[2*i]);
      nboth += int'(d[2*i+1] & d[2*i]);
    end
    bad = nboth > 0;
    full = nany == 4 && !bad;
    if (reset) begin
      ph = 0; m_cnt = 0; m_prev = m_s2; m_tmo = 0; m_perr = 0; m_data = '0;
      for (int r = 0; r < 8; r++) at[r] = -1;
    end else begin
      if (bad || full) m_prev = m_s2;
      if (ph == 1) begin
        m_cnt = m_cnt < TO ? m_cnt + 1 : TO;
        if (m_cnt == TO) m_tmo = 1;
        if (bad) begin
          m_perr = 1;
          ph = 0;
        end else if (full) begin
          for (int i = 0; i < 4; i++) m_data[i] = d[2*i+1];
          ph = 2;
        end
      end else begin
        if (bad || full) m_perr = 1;
        if (ph == 2 && resp_ready) ph = 0;
        else if (ph == 0 && req_valid) begin
          for (int i = 0; i < 4; i++) begin
            m_ui[2*i+int'(req_data[i])] = ~m_ui[2*i+int'(req_data[i])];
            dl = mode == 1 ? 5 + 3 * i : mode == 2 ? 1100 : 5;
            at[2*i+int'(!req_data[i])] = cyc + dl;
            if (mode == 3 && i == 2) at[2*i+int'(req_data[i])] = cyc + dl;
          end
          ph = 1;
          m_cnt = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = uo;
  endtask

  task automatic compare_all();
    chk("req_ready", 32'(!reset && ph == 0), 32'(req_ready));
    chk("resp_valid", 32'(resp_valid), 32'(!reset && ph == 2));
    if (!reset && ph == 2) chk("resp_data", 32'(resp_data), 32'(m_data));
    if (reset) chk("resp_data_rst", 32'(resp_data), 32'(0));
    chk("timeout", 32'(timeout), 32'(!reset && m_tmo));
    chk("proto_err", 32'(proto_err), 32'(!reset && m_perr));
    chk("user_input", 32'(user_input), 32'(m_ui));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1 compare_all();
    @(negedge clk);
    for (int r = 0; r < 8; r++) if (at[r] == cyc) uo[r] = ~uo[r];
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!resp_valid && n < lim) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    repeat (4) tick();
    chk("reset_ui", 32'(user_input), 32'h00);
    chk("reset_ready", 32'(req_ready), 32'(0));
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(req_ready), 32'(1));
    // plain echo of 1010
    mode = 0; req_data = 4'b1010; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("enc_1010", 32'(user_input), 32'h99);
    chk("busy_after_accept", 32'(req_ready), 32'(0));
    wait_valid(40, n);
    chk("echo_latency", n, 8);
    chk("dec_0101", 32'(resp_data), 32'(4'b0101));
    repeat (10) tick();
    chk("hold_data", 32'(resp_data), 32'(4'b0101));
    chk("hold_busy", 32'(req_ready), 32'(0));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("ready_after_hs", 32'(req_ready), 32'(1));
    // skewed echo, issued right after the handshake
    mode = 1; req_data = 4'b0110; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("accept_after_hs", 32'(req_ready), 32'(0));
    chk("enc_0110", 32'(user_input), 32'hF0);
    wait_valid(40, n);
    chk("skew_latency", n, 17);
    chk("dec_skew", 32'(resp_data), 32'(4'b1001));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    // withheld echo trips timeout, late echo still completes
    mode = 2; req_data = 4'b0001; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!timeout && n < 1100) begin
      tick();
      n++;
    end
    chk("timeout_at", n, 1024);
    while (!resp_valid && n < 1200) begin
      tick();
      n++;
    end
    chk("late_latency", n, 1103);
    chk("timeout_sticky", 32'(timeout), 32'(1));
    chk("dec_late", 32'(resp_data), 32'(4'b1110));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    // both rails of bit 2 toggle
    mode = 3; req_data = 4'b0101; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!proto_err && n < 40) begin
      tick();
      n++;
    end
    chk("perr_latency", n, 8);
    chk("perr_no_resp", 32'(resp_valid), 32'(0));
    chk("perr_idle", 32'(req_ready), 32'(1));
    // reset in the middle of WAIT
    mode = 0; req_data = 4'b1100; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_idle", 32'(req_ready), 32'(1));
    chk("rst_tmo", 32'(timeout), 32'(0));
    chk("rst_perr", 32'(proto_err), 32'(0));
    chk("rst_ui", 32'(user_input), 32'h65);
    req_data = 4'b0011; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_valid(40, n);
    chk("rst_echo_latency", n, 8);
    chk("dec_after_rst", 32'(resp_data), 32'(4'b1100));
    resp_ready = 1'b1;
    tick();
    // random traffic
    for (int c = 0; c < 600; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_data = 4'($urandom);
      resp_ready = $urandom_range(0, 3) != 0;
      mode = $urandom_range(0, 7) == 0 ? 3 : int'($urandom_range(0, 1));
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (30) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
